piso_serializer: RTL and testbench

//   Parallel-in/serial-out stage feeding the serial D input of the 6-bit SIPO shift register.

---
 rtl/piso_serializer.sv | 122 ++++++++++++
 tb/tb_piso_serializer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out word serializer with valid/ready load handshake
// Optional build macro PARITY_EN appends an even-parity bit after each word.
module piso_serializer #(
    parameter int WIDTH     = 6,
    parameter int MSB_FIRST = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load_valid,
    output logic             Load_ready,
    input  logic [WIDTH-1:0] Din,
    output logic             Dout,
    output logic             Dout_valid,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic par_bit;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_bit;
    logic             final_cycle;
    logic             head_bit;

    // The bit on the line is always the head of the shift register, so Dout comes straight from flops.
    always_comb begin
        head_bit    = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
        last_bit    = (state == SHIFT) && (cnt == LAST);
`ifdef PARITY_EN
        final_cycle = (state == PAR);
`else
        final_cycle = last_bit;
`endif
        Load_ready  = (state == IDLE) || final_cycle;
        accept      = Load_valid && Load_ready;
        Busy        = (state != IDLE);
        Dout_valid  = Busy;
        Done        = final_cycle;
        Dout        = 1'b0;
        if (state == SHIFT) begin
            Dout = head_bit;
        end
`ifdef PARITY_EN
        else if (state == PAR) begin
            Dout = par_bit;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            PAR: begin
                state_nxt = accept ? SHIFT : IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A load in the final cycle reloads the register directly, giving a gapless stream.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= Din;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            sreg <= (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            par_bit <= 1'b0;
        end else if (accept) begin
            par_bit <= ^Din;
        end
    end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lv  = 1'b0;
    logic [5:0] din = 6'h00;

    logic rdy_m, dout_m, dv_m, busy_m, done_m;
    logic rdy_l, dout_l, dv_l, busy_l, done_l;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(6), .MSB_FIRST(1)) u_msb (
        .Clock(clk), .Reset(rst), .Load_valid(lv), .Load_ready(rdy_m), .Din(din),
        .Dout(dout_m), .Dout_valid(dv_m), .Busy(busy_m), .Done(done_m)
    );

    piso_serializer #(.WIDTH(6), .MSB_FIRST(0)) u_lsb (
        .Clock(clk), .Reset(rst), .Load_valid(lv), .Load_ready(rdy_l), .Din(din),
        .Dout(dout_l), .Dout_valid(dv_l), .Busy(busy_l), .Done(done_l)
    );

    // outputs are {dout, dout_valid, busy, done, load_ready} seen in the cycle after the edge
    typedef struct {
        logic       rst;
        logic       lv;
        logic [5:0] din;
        logic [4:0] exp;
    } vec_t;

    localparam logic [4:0] O_IDLE = 5'b00001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [5:0] d);
        rst = r;
        lv  = v;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [5:0] w, input int nbits,
                             output logic [7:0] mbits, output logic [7:0] lbits,
                             output int ndone, output logic last_done);
        mbits = '0;
        lbits = '0;
        ndone = 0;
        last_done = 1'b0;
        step(1'b0, 1'b1, w);
        lv = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            chk($sformatf("dv_bit%0d", i), {31'd0, dv_m & dv_l}, 32'd1);
            mbits = {mbits[6:0], dout_m};
            lbits = {lbits[6:0], dout_l};
            ndone += int'(done_m);
            last_done = done_m & done_l;
            @(posedge clk);
            #1;
        end
        chk("idle_after_word", {27'd0, dout_m, dv_m, busy_m, done_m, rdy_m}, {27'd0, O_IDLE});
    endtask

    vec_t vecs[$];
    logic [7:0] mb, lb;
    int nd;
    logic ld;

    initial begin
        // T1: reset with a load pending, then idle
        vecs.push_back('{1'b1, 1'b1, 6'h3F, O_IDLE});
        vecs.push_back('{1'b1, 1'b1, 6'h3F, O_IDLE});
        vecs.push_back('{1'b0, 1'b0, 6'h3F, O_IDLE});
        vecs.push_back('{1'b0, 1'b0, 6'h00, O_IDLE});
`ifndef PARITY_EN
        // T2: 101101
        vecs.push_back('{1'b0, 1'b1, 6'b101101, 5'b11100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'b01100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'b11100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'b11100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'b01100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'b11111});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, O_IDLE});
        // T3: 110011 then 000111 held valid, accepted in the Done cycle
        vecs.push_back('{1'b0, 1'b1, 6'b110011, 5'b11100});
        vecs.push_back('{1'b0, 1'b1, 6'b000111, 5'b11100});
        vecs.push_back('{1'b0, 1'b1, 6'b000111, 5'b01100});
        vecs.push_back('{1'b0, 1'b1, 6'b000111, 5'b01100});
        vecs.push_back('{1'b0, 1'b1, 6'b000111, 5'b11100});
        vecs.push_back('{1'b0, 1'b1, 6'b000111, 5'b11111});
        vecs.push_back('{1'b0, 1'b1, 6'b000111, 5'b01100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'b01100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'b01100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'b11100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'b11100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, 5'b11111});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, O_IDLE});
        // T4: 100000 with ignored loads of 111111 mid-word
        vecs.push_back('{1'b0, 1'b1, 6'b100000, 5'b11100});
        vecs.push_back('{1'b0, 1'b1, 6'b111111, 5'b01100});
        vecs.push_back('{1'b0, 1'b0, 6'b111111, 5'b01100});
        vecs.push_back('{1'b0, 1'b1, 6'b111111, 5'b01100});
        vecs.push_back('{1'b0, 1'b0, 6'b111111, 5'b01100});
        vecs.push_back('{1'b0, 1'b1, 6'b111111, 5'b01111});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, O_IDLE});
        vecs.push_back('{1'b0, 1'b0, 6'b000000, O_IDLE});
`endif

        #1;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].lv, vecs[i].din);
            chk($sformatf("vec%0d", i), {27'd0, dout_m, dv_m, busy_m, done_m, rdy_m},
                {27'd0, vecs[i].exp});
        end

        // T5: reset during cycle k+3 aborts the word
        step(1'b0, 1'b1, 6'b111111);
        lv = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("t5_bit%0d", i), {29'd0, dout_m, dv_m, busy_m}, 32'd7);
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        step(1'b1, 1'b0, 6'b000000);
        chk("t5_after_reset", {27'd0, dout_m, dv_m, busy_m, done_m, rdy_m}, {27'd0, O_IDLE});
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            nd += int'(dv_m | dout_m | dv_l | dout_l);
        end
        chk("t5_no_replay", nd, 0);

        // T6 and bit order: both instances share the word
`ifdef PARITY_EN
        send_word(6'b101100, 7, mb, lb, nd, ld);
        chk("t6_msb_bits", {24'd0, mb}, {24'd0, 8'b01011001});
        chk("t6_lsb_bits", {24'd0, lb}, {24'd0, 8'b00011011});
        chk("t6_done_cnt", nd, 1);
        chk("t6_done_last", {31'd0, ld}, 32'd1);
        send_word(6'b000001, 7, mb, lb, nd, ld);
        chk("t6b_lsb_bits", {24'd0, lb}, {24'd0, 8'b01000001});
        chk("t6b_msb_bits", {24'd0, mb}, {24'd0, 8'b00000011});
`else
        send_word(6'b101100, 6, mb, lb, nd, ld);
        chk("ord_msb_bits", {24'd0, mb}, {24'd0, 8'b00101100});
        chk("ord_lsb_bits", {24'd0, lb}, {24'd0, 8'b00001101});
        chk("ord_done_cnt", nd, 1);
        chk("ord_done_last", {31'd0, ld}, 32'd1);
        send_word(6'b000001, 6, mb, lb, nd, ld);
        chk("lsb1_lsb_bits", {24'd0, lb}, {24'd0, 8'b00100000});
        chk("lsb1_msb_bits", {24'd0, mb}, {24'd0, 8'b00000001});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
